// File: rtl/isa_load_arbiter.sv
// Instruction-RAM port owner: queues 128-bit load lines, writes each as four 32-bit beats,
// and shares the single RAM port with CPU fetches under a bounded-starvation policy.
module isa_load_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk_cpu,
  input  logic         rst,
  input  logic [127:0] isa_data_i,
  input  logic [15:0]  isa_addr_i,
  input  logic         isa_wren_i,
  input  logic         cpu_fetch_req,
  input  logic [17:0]  cpu_fetch_addr,
  output logic         cpu_fetch_gnt,
  output logic         cpu_fetch_valid,
  output logic [31:0]  cpu_fetch_data,
  output logic         ram_en,
  output logic         ram_we,
  output logic [17:0]  ram_addr,
  output logic [31:0]  ram_wdata,
  input  logic [31:0]  ram_rdata,
  input  logic         clr_err_i,
  output logic         busy_o,
  output logic         overflow_o,
  output logic [15:0]  lines_done_o
);

  localparam int unsigned RAM_AW = 18;
  localparam int unsigned LAW    = 16;
  localparam int unsigned LDW    = 128;
  localparam int unsigned EW     = LAW + LDW;
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned SW     = $clog2(STARVE_MAX + 1) + 1;
  localparam int unsigned LCW    = 16;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     fifo_q [DEPTH];
  logic [EW-1:0]     fifo_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LDW-1:0]    line_q, line_d;
  logic [LAW-1:0]    line_addr_q, line_addr_d;
  logic [1:0]        beat_q, beat_d;
  logic [LCW-1:0]    lines_done_q, lines_done_d;
  logic              overflow_q, overflow_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              fetch_valid_q, fetch_valid_d;

  logic              empty, full, cpu_win, ld_gnt, last_beat, pop, push, drop;
  logic [EW-1:0]     head;

  // Port arbitration: the CPU wins when the loader is idle or the fetch has waited long enough.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    cpu_win   = cpu_fetch_req & ((state_q == S_IDLE) | (starve_q >= SW'(STARVE_MAX)));
    ld_gnt    = (state_q == S_WRITE) & ~cpu_win;
    last_beat = ld_gnt & (beat_q == 2'd3);
    pop       = ~empty & ((state_q == S_IDLE) | last_beat);
    push      = isa_wren_i & (~full | pop);
    drop      = isa_wren_i & full & ~pop;
    head      = fifo_q[rd_ptr_q];
  end

  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    line_d        = line_q;
    line_addr_d   = line_addr_q;
    beat_d        = beat_q;
    lines_done_d  = lines_done_q;
    overflow_d    = overflow_q;
    starve_d      = starve_q;
    fetch_valid_d = cpu_win;

    if (ld_gnt) begin
      beat_d = beat_q + 2'd1;
      if (last_beat) begin
        lines_done_d = lines_done_q + LCW'(1);
        if (empty) state_d = S_IDLE;
      end
    end

    // A pop refills the line register with no bubble between lines.
    if (pop) begin
      line_d      = head[LDW-1:0];
      line_addr_d = head[EW-1:LDW];
      rd_ptr_d    = rd_ptr_q + PW'(1);
      beat_d      = 2'd0;
      state_d     = S_WRITE;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = {isa_addr_i, isa_data_i};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)           overflow_d = 1'b1;
    else if (clr_err_i) overflow_d = 1'b0;

    if (cpu_win)                                         starve_d = '0;
    else if (cpu_fetch_req && starve_q < SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      line_q        <= '0;
      line_addr_q   <= '0;
      beat_q        <= '0;
      lines_done_q  <= '0;
      overflow_q    <= 1'b0;
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      line_q        <= line_d;
      line_addr_q   <= line_addr_d;
      beat_q        <= beat_d;
      lines_done_q  <= lines_done_d;
      overflow_q    <= overflow_d;
      starve_q      <= starve_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Port drive; everything visible is forced quiet while reset is held.
  always_comb begin
    ram_en          = ~rst & (cpu_win | ld_gnt);
    ram_we          = ~rst & ld_gnt;
    ram_addr        = ld_gnt ? {line_addr_q, beat_q} : RAM_AW'(cpu_fetch_addr);
    ram_wdata       = line_q[{beat_q, 5'd0} +: 32];
    cpu_fetch_gnt   = ~rst & cpu_win;
    cpu_fetch_valid = ~rst & fetch_valid_q;
    cpu_fetch_data  = ram_rdata;
    busy_o          = ~rst & (~empty | (state_q != S_IDLE));
    overflow_o      = ~rst & overflow_q;
    lines_done_o    = rst ? '0 : lines_done_q;
  end

endmodule

// File: tb/tb_isa_load_arbiter.sv
// Scoreboard bench for isa_load_arbiter: stimulus queues expected RAM writes and fetch
// returns, a negedge monitor pops and compares whenever the DUT drives the port.
module tb_isa_load_arbiter;

  logic         clk_cpu = 1'b0;
  logic         rst;
  logic [127:0] isa_data_i;
  logic [15:0]  isa_addr_i;
  logic         isa_wren_i;
  logic         cpu_fetch_req;
  logic [17:0]  cpu_fetch_addr;
  logic         cpu_fetch_gnt;
  logic         cpu_fetch_valid;
  logic [31:0]  cpu_fetch_data;
  logic         ram_en;
  logic         ram_we;
  logic [17:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata = 32'h0;
  logic         clr_err_i;
  logic         busy_o;
  logic         overflow_o;
  logic [15:0]  lines_done_o;

  always #5 clk_cpu = ~clk_cpu;

  isa_load_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
    .clk_cpu(clk_cpu), .rst(rst),
    .isa_data_i(isa_data_i), .isa_addr_i(isa_addr_i), .isa_wren_i(isa_wren_i),
    .cpu_fetch_req(cpu_fetch_req), .cpu_fetch_addr(cpu_fetch_addr),
    .cpu_fetch_gnt(cpu_fetch_gnt), .cpu_fetch_valid(cpu_fetch_valid),
    .cpu_fetch_data(cpu_fetch_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .clr_err_i(clr_err_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .lines_done_o(lines_done_o)
  );

  // Instruction RAM model with 1-cycle read latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk_cpu) begin
    if (ram_en && ram_we)  mem[ram_addr[10:0]] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[10:0]];
  end

  int total = 0;
  int bad   = 0;

  logic [49:0] wr_exp [$];
  logic [49:0] rd_exp [$];
  logic        rd_pending = 1'b0;
  logic [31:0] rd_data_exp = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every port access is matched against the scoreboard queues.
  always @(negedge clk_cpu) begin
    logic [49:0] e;
    if (rst) begin
      chk("rst_quiet", 64'({ram_en, ram_we, cpu_fetch_gnt, cpu_fetch_valid, busy_o, overflow_o}), 64'h0);
      chk("rst_lines", 64'(lines_done_o), 64'h0);
      rd_pending = 1'b0;
    end else begin
      if (rd_pending) begin
        chk("fetch_valid", 64'(cpu_fetch_valid), 64'h1);
        chk("fetch_data", 64'(cpu_fetch_data), 64'(rd_data_exp));
      end else if (cpu_fetch_valid) begin
        chk("fetch_valid_unexp", 64'(cpu_fetch_valid), 64'h0);
      end
      rd_pending = 1'b0;
      if (ram_en && ram_we) begin
        if (wr_exp.size() == 0) begin
          chk("write_unexp", 64'({ram_addr, ram_wdata}), 64'h0);
        end else begin
          e = wr_exp.pop_front();
          chk("wr_addr", 64'(ram_addr), 64'(e[49:32]));
          chk("wr_data", 64'(ram_wdata), 64'(e[31:0]));
        end
      end
      if (cpu_fetch_gnt) begin
        chk("gnt_port", 64'({ram_en, ram_we}), 64'h2);
        if (rd_exp.size() == 0) begin
          chk("gnt_unexp", 64'(cpu_fetch_gnt), 64'h0);
        end else begin
          e = rd_exp.pop_front();
          chk("rd_addr", 64'(ram_addr), 64'(e[49:32]));
          rd_pending  = 1'b1;
          rd_data_exp = e[31:0];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic push_line(input logic [15:0] a, input logic [127:0] d, input bit expect_it);
    isa_addr_i = a;
    isa_data_i = d;
    isa_wren_i = 1'b1;
    if (expect_it)
      for (int k = 0; k < 4; k++) wr_exp.push_back({a, 2'(k), d[32*k +: 32]});
    cyc();
    isa_wren_i = 1'b0;
  endtask

  // Counts negedges with busy_o high until it drops.
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk_cpu);
    while (busy_o && n < 500) begin
      n++;
      @(negedge clk_cpu);
    end
    if (busy_o) chk("idle_timeout", 64'(busy_o), 64'h0);
    cyc();
  endtask

  // Holds a fetch until granted; w = number of losing cycles.
  task automatic fetch(input logic [17:0] a, input logic [31:0] d, output int w);
    rd_exp.push_back({a, d});
    cpu_fetch_req  = 1'b1;
    cpu_fetch_addr = a;
    w = 0;
    @(negedge clk_cpu);
    while (!cpu_fetch_gnt && w < 100) begin
      w++;
      @(negedge clk_cpu);
    end
    if (!cpu_fetch_gnt) chk("gnt_timeout", 64'(cpu_fetch_gnt), 64'h1);
    cyc();
    cpu_fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    logic [127:0] d;

    rst = 1'b1; isa_data_i = '0; isa_addr_i = '0; isa_wren_i = 1'b0;
    cpu_fetch_req = 1'b0; cpu_fetch_addr = '0; clr_err_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk_cpu);
    chk("reset_busy", 64'(busy_o), 64'h0);
    chk("reset_ovf", 64'(overflow_o), 64'h0);
    chk("reset_lines", 64'(lines_done_o), 64'h0);
    cyc();

    // Single line at 0x0010 -> word addresses 0x40..0x43.
    wr_exp.push_back({18'h00040, 32'h11111111});
    wr_exp.push_back({18'h00041, 32'h22222222});
    wr_exp.push_back({18'h00042, 32'h33333333});
    wr_exp.push_back({18'h00043, 32'h44444444});
    push_line(16'h0010, 128'h44444444_33333333_22222222_11111111, 1'b0);
    wait_idle(n);
    chk("t1_busy_cycles", 64'(n), 64'd5);
    chk("t1_lines", 64'(lines_done_o), 64'd1);

    // Fetch while idle: granted immediately, returns the word written above.
    fetch(18'h00041, 32'h22222222, w);
    chk("t4_wait", 64'(w), 64'd0);
    cyc();

    // Burst of 7: the serializer drains one line mid-burst, so only the seventh is dropped;
    // a clear coinciding with that drop must not win.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'hB000_0000 | (i << 8) | k;
      clr_err_i = (i == 6);
      push_line(16'h0100 + 16'(i), d, i < 6);
      clr_err_i = 1'b0;
    end
    @(negedge clk_cpu);
    chk("t2_ovf_set", 64'(overflow_o), 64'h1);
    wait_idle(n);
    chk("t2_lines", 64'(lines_done_o), 64'd7);
    chk("t2_ovf_sticky", 64'(overflow_o), 64'h1);
    clr_err_i = 1'b1;
    cyc();
    clr_err_i = 1'b0;
    @(negedge clk_cpu);
    chk("t2_ovf_clr", 64'(overflow_o), 64'h0);
    cyc();

    // Fetch held during a 3-line load: 4 losing cycles, then loader resumes.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'hC000_0000 | (i << 8) | k;
      push_line(16'h0020 + 16'(i), d, 1'b1);
    end
    fetch(18'h00042, 32'h33333333, w);
    chk("t3_wait", 64'(w), 64'd4);
    @(negedge clk_cpu);
    chk("t3_resume", 64'({ram_en, ram_we}), 64'h3);
    wait_idle(n);
    chk("t3_lines", 64'(lines_done_o), 64'd10);

    // Reset at beat 2 of a line: only beats 0 and 1 may reach the RAM.
    wr_exp.push_back({18'h000C0, 32'hD0000000});
    wr_exp.push_back({18'h000C1, 32'hD0000001});
    push_line(16'h0030, 128'hD0000003_D0000002_D0000001_D0000000, 1'b0);
    repeat (3) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk_cpu);
    chk("t5_busy", 64'(busy_o), 64'h0);
    chk("t5_lines", 64'(lines_done_o), 64'h0);
    chk("t5_flushed", 64'(wr_exp.size()), 64'h0);
    cyc();
    push_line(16'h0031, 128'hE0000003_E0000002_E0000001_E0000000, 1'b1);
    wait_idle(n);
    chk("t5_after_lines", 64'(lines_done_o), 64'd1);

    repeat (2) cyc();
    chk("end_wr_queue", 64'(wr_exp.size()), 64'h0);
    chk("end_rd_queue", 64'(rd_exp.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
